// File: rtl/mcs4_timing_pkg.sv
// Shared types for the 4004 timing stage: subcycle and quarter-phase encodings.
package mcs4_timing_pkg;

  localparam int SUBCYCLES = 8;
  localparam int QUARTERS  = 4;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } subcycle_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

endpackage

// File: rtl/phase_divider.sv
// Quarter-phase divider: PHASE_LEN sysclk per quarter, walking Q0..Q3.
// Exports next-state values so the top can register its outputs on the same edge.
module phase_divider
  import mcs4_timing_pkg::*;
#(
  parameter int PHASE_LEN = 17
) (
  input  logic       sysclk,
  input  logic       poc_n,
  output logic [1:0] quarter,
  output logic [1:0] quarter_next,
  output logic       advance,
  output logic       clk1_next,
  output logic       clk2_next
);

  quarter_t q_q;
  quarter_t q_next;

  // With PHASE_LEN=1 there is nothing to count: the quarter moves every sysclk.
  generate
    if (PHASE_LEN > 1) begin : g_qcnt
      localparam int CW = $clog2(PHASE_LEN);
      localparam logic [CW-1:0] QCNT_LAST = CW'(PHASE_LEN - 1);
      logic [CW-1:0] qcnt;

      always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
          qcnt <= QCNT_LAST;
        end else if (qcnt == QCNT_LAST) begin
          qcnt <= '0;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end

      assign advance = (qcnt == QCNT_LAST);
    end else begin : g_no_qcnt
      assign advance = 1'b1;
    end
  endgenerate

  always_comb begin
    q_next = q_q;
    if (advance) begin
      q_next = quarter_t'(q_q + 2'd1);
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      q_q <= Q3;
    end else begin
      q_q <= q_next;
    end
  end

  assign quarter      = q_q;
  assign quarter_next = q_next;
  assign clk1_next    = (q_next == Q0);
  assign clk2_next    = (q_next == Q2);

endmodule

// File: rtl/timing_generator.sv
// 4004 timing generator: subcycle ring, phase-1/phase-2 state strobes and Power-On Clear.
// Every output is a register loaded from the next state, so all ports change together.
module timing_generator
  import mcs4_timing_pkg::*;
#(
  parameter int PHASE_LEN  = 17,
  parameter int POC_CYCLES = 4
) (
  input  logic       sysclk,
  input  logic       poc_n,
  output logic       clk1,
  output logic       clk2,
  output logic       sync,
  output logic       a11,
  output logic       a21,
  output logic       a31,
  output logic       m11,
  output logic       m21,
  output logic       x11,
  output logic       x21,
  output logic       x31,
  output logic       a12,
  output logic       a22,
  output logic       a32,
  output logic       m12,
  output logic       m22,
  output logic       x12,
  output logic       x22,
  output logic       x32,
  output logic       m12_m22_clk1_m11_m12,
  output logic [2:0] subcycle,
  output logic       poc
);

  localparam int PW = $clog2(POC_CYCLES + 1);
  localparam logic [PW-1:0] POC_LAST = PW'(POC_CYCLES);

  logic [1:0] quarter_raw;
  logic [1:0] quarter_next_raw;
  logic       advance;
  logic       clk1_next;
  logic       clk2_next;

  phase_divider #(
    .PHASE_LEN(PHASE_LEN)
  ) u_phase_divider (
    .sysclk      (sysclk),
    .poc_n       (poc_n),
    .quarter     (quarter_raw),
    .quarter_next(quarter_next_raw),
    .advance     (advance),
    .clk1_next   (clk1_next),
    .clk2_next   (clk2_next)
  );

  quarter_t              quarter;
  quarter_t              quarter_next;
  subcycle_t             sub_q;
  subcycle_t             sub_next;
  logic [2:0]            sub_inc;
  logic [2:0]            sub_dec;
  logic [SUBCYCLES-1:0]  p1_q;
  logic [SUBCYCLES-1:0]  p2_q;
  logic [SUBCYCLES-1:0]  p1_next;
  logic [SUBCYCLES-1:0]  p2_next;
  logic                  p2_valid_q;
  logic                  p2_valid_next;
  logic                  sync_next;
  logic                  comp_q;
  logic                  comp_next;
  logic                  entering_a1;
  logic                  poc_next;
  logic [PW-1:0]         poc_cnt;
  logic [PW-1:0]         poc_cnt_next;

  assign quarter      = quarter_t'(quarter_raw);
  assign quarter_next = quarter_t'(quarter_next_raw);

  // Phase-2 strobes lag phase-1 by half a subcycle; p2_valid keeps x32 quiet
  // until the first Q2 after reset, since no X3 preceded the first A1.
  always_comb begin
    sub_inc       = sub_q + 3'd1;
    entering_a1   = advance && (quarter == Q3) && (sub_q == X3);
    sub_next      = (advance && (quarter == Q3)) ? subcycle_t'(sub_inc) : sub_q;
    sub_dec       = sub_next - 3'd1;
    p1_next       = SUBCYCLES'(1) << sub_next;
    p2_valid_next = p2_valid_q | (quarter_next == Q2);
    p2_next       = '0;
    if (p2_valid_next) begin
      if ((quarter_next == Q2) || (quarter_next == Q3)) begin
        p2_next = SUBCYCLES'(1) << sub_next;
      end else begin
        p2_next = SUBCYCLES'(1) << sub_dec;
      end
    end
    sync_next = (sub_next == A1) && (quarter_next == Q0);
    comp_next = p2_next[M1] | p2_next[M2] | (clk1_next & ~(p1_next[M1] | p2_next[M1]));
    poc_next     = poc;
    poc_cnt_next = poc_cnt;
    if (poc && entering_a1) begin
      if (poc_cnt == POC_LAST) begin
        poc_next = 1'b0;
      end else begin
        poc_cnt_next = poc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      sub_q      <= X3;
      p1_q       <= '0;
      p2_q       <= '0;
      p2_valid_q <= 1'b0;
      clk1       <= 1'b0;
      clk2       <= 1'b0;
      sync       <= 1'b0;
      comp_q     <= 1'b0;
      poc        <= 1'b1;
      poc_cnt    <= '0;
    end else begin
      sub_q      <= sub_next;
      p1_q       <= p1_next;
      p2_q       <= p2_next;
      p2_valid_q <= p2_valid_next;
      clk1       <= clk1_next;
      clk2       <= clk2_next;
      sync       <= sync_next;
      comp_q     <= comp_next;
      poc        <= poc_next;
      poc_cnt    <= poc_cnt_next;
    end
  end

  assign {x31, x21, x11, m21, m11, a31, a21, a11} = p1_q;
  assign {x32, x22, x12, m22, m12, a32, a22, a12} = p2_q;
  assign m12_m22_clk1_m11_m12 = comp_q;
  assign subcycle = sub_q;

endmodule

// File: tb/tb_timing_generator.sv
// Bench for timing_generator: three instances (PHASE_LEN=2/POC=1, PHASE_LEN=2/POC=4,
// PHASE_LEN=1/POC=1) driven from one sysclk, each with its own reset.
module tb_timing_generator;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rst_a, rst_b, rst_c;

  logic       clk1_a, clk2_a, sync_a, comp_a, poc_a;
  logic [7:0] p1_a, p2_a;
  logic [2:0] sub_a;
  logic       clk1_b, clk2_b, sync_b, comp_b, poc_b;
  logic [7:0] p1_b, p2_b;
  logic [2:0] sub_b;
  logic       clk1_c, clk2_c, sync_c, comp_c, poc_c;
  logic [7:0] p1_c, p2_c;
  logic [2:0] sub_c;

  timing_generator #(.PHASE_LEN(2), .POC_CYCLES(1)) dut_a (
    .sysclk(sysclk), .poc_n(rst_a), .clk1(clk1_a), .clk2(clk2_a), .sync(sync_a),
    .a11(p1_a[0]), .a21(p1_a[1]), .a31(p1_a[2]), .m11(p1_a[3]),
    .m21(p1_a[4]), .x11(p1_a[5]), .x21(p1_a[6]), .x31(p1_a[7]),
    .a12(p2_a[0]), .a22(p2_a[1]), .a32(p2_a[2]), .m12(p2_a[3]),
    .m22(p2_a[4]), .x12(p2_a[5]), .x22(p2_a[6]), .x32(p2_a[7]),
    .m12_m22_clk1_m11_m12(comp_a), .subcycle(sub_a), .poc(poc_a)
  );

  timing_generator #(.PHASE_LEN(2), .POC_CYCLES(4)) dut_b (
    .sysclk(sysclk), .poc_n(rst_b), .clk1(clk1_b), .clk2(clk2_b), .sync(sync_b),
    .a11(p1_b[0]), .a21(p1_b[1]), .a31(p1_b[2]), .m11(p1_b[3]),
    .m21(p1_b[4]), .x11(p1_b[5]), .x21(p1_b[6]), .x31(p1_b[7]),
    .a12(p2_b[0]), .a22(p2_b[1]), .a32(p2_b[2]), .m12(p2_b[3]),
    .m22(p2_b[4]), .x12(p2_b[5]), .x22(p2_b[6]), .x32(p2_b[7]),
    .m12_m22_clk1_m11_m12(comp_b), .subcycle(sub_b), .poc(poc_b)
  );

  timing_generator #(.PHASE_LEN(1), .POC_CYCLES(1)) dut_c (
    .sysclk(sysclk), .poc_n(rst_c), .clk1(clk1_c), .clk2(clk2_c), .sync(sync_c),
    .a11(p1_c[0]), .a21(p1_c[1]), .a31(p1_c[2]), .m11(p1_c[3]),
    .m21(p1_c[4]), .x11(p1_c[5]), .x21(p1_c[6]), .x31(p1_c[7]),
    .a12(p2_c[0]), .a22(p2_c[1]), .a32(p2_c[2]), .m12(p2_c[3]),
    .m22(p2_c[4]), .x12(p2_c[5]), .x22(p2_c[6]), .x32(p2_c[7]),
    .m12_m22_clk1_m11_m12(comp_c), .subcycle(sub_c), .poc(poc_c)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edge_n;
    logic       clk1;
    logic       clk2;
    logic       sync;
    logic       poc;
    logic       comp;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [2:0] sub;
  } vec_t;

  vec_t vecs[20];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance n active edges and return on the following falling edge.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge sysclk);
      @(negedge sysclk);
    end
  endtask

  task automatic check_vec_a(input vec_t v);
    string t;
    t = $sformatf("edge%0d", v.edge_n);
    check_output({t, " clk1"}, 32'(clk1_a), 32'(v.clk1));
    check_output({t, " clk2"}, 32'(clk2_a), 32'(v.clk2));
    check_output({t, " sync"}, 32'(sync_a), 32'(v.sync));
    check_output({t, " poc"},  32'(poc_a),  32'(v.poc));
    check_output({t, " comp"}, 32'(comp_a), 32'(v.comp));
    check_output({t, " p1"},   32'(p1_a),   32'(v.p1));
    check_output({t, " p2"},   32'(p2_a),   32'(v.p2));
    check_output({t, " sub"},  32'(sub_a),  32'(v.sub));
  endtask

  // Expected dut_a outputs after the given edge following reset release
  // (PHASE_LEN=2: quarter = 2 edges, subcycle = 8 edges, cycle = 64 edges).
  task automatic load_vectors();
    //            edge clk1 clk2 sync poc comp p1     p2     sub
    vecs[0]  = '{ 0,  0, 0, 0, 1, 0, 8'h00, 8'h00, 3'd7};
    vecs[1]  = '{ 1,  1, 0, 1, 1, 1, 8'h01, 8'h00, 3'd0};
    vecs[2]  = '{ 3,  0, 0, 0, 1, 0, 8'h01, 8'h00, 3'd0};
    vecs[3]  = '{ 5,  0, 1, 0, 1, 0, 8'h01, 8'h01, 3'd0};
    vecs[4]  = '{ 7,  0, 0, 0, 1, 0, 8'h01, 8'h01, 3'd0};
    vecs[5]  = '{ 9,  1, 0, 0, 1, 1, 8'h02, 8'h01, 3'd1};
    vecs[6]  = '{11,  0, 0, 0, 1, 0, 8'h02, 8'h01, 3'd1};
    vecs[7]  = '{13,  0, 1, 0, 1, 0, 8'h02, 8'h02, 3'd1};
    vecs[8]  = '{25,  1, 0, 0, 1, 0, 8'h08, 8'h04, 3'd3};
    vecs[9]  = '{29,  0, 1, 0, 1, 1, 8'h08, 8'h08, 3'd3};
    vecs[10] = '{33,  1, 0, 0, 1, 1, 8'h10, 8'h08, 3'd4};
    vecs[11] = '{37,  0, 1, 0, 1, 1, 8'h10, 8'h10, 3'd4};
    vecs[12] = '{41,  1, 0, 0, 1, 1, 8'h20, 8'h10, 3'd5};
    vecs[13] = '{45,  0, 1, 0, 1, 0, 8'h20, 8'h20, 3'd5};
    vecs[14] = '{57,  1, 0, 0, 1, 1, 8'h80, 8'h40, 3'd7};
    vecs[15] = '{61,  0, 1, 0, 1, 0, 8'h80, 8'h80, 3'd7};
    vecs[16] = '{64,  0, 0, 0, 1, 0, 8'h80, 8'h80, 3'd7};
    vecs[17] = '{65,  1, 0, 1, 0, 1, 8'h01, 8'h80, 3'd0};
    vecs[18] = '{67,  0, 0, 0, 0, 0, 8'h01, 8'h80, 3'd0};
    vecs[19] = '{69,  0, 1, 0, 0, 0, 8'h01, 8'h01, 3'd0};
  endtask

  initial begin
    int         edge_cnt;
    int         clk1_cnt;
    int         p1_cnt[8];
    int         p2_cnt[8];
    int         last_rise;
    logic       prev_sync;
    logic [7:0] p1_hist[$];
    logic [7:0] old_p1;

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    load_vectors();
    apply_stimulus(3);

    $display("[TB] reset state");
    check_vec_a(vecs[0]);
    check_output("b reset poc", 32'(poc_b), 32'd1);
    check_output("b reset sub", 32'(sub_b), 32'd7);
    check_output("c reset strobes", 32'({p1_c, p2_c, clk1_c, clk2_c}), 32'd0);

    $display("[TB] reset release and first instruction cycle (dut_a)");
    rst_a    = 1'b1;
    edge_cnt = 0;
    for (int i = 1; i < 20; i++) begin
      while (edge_cnt < vecs[i].edge_n) begin
        apply_stimulus(1);
        edge_cnt++;
      end
      check_vec_a(vecs[i]);
    end

    $display("[TB] free run over three instruction cycles (dut_a)");
    while (edge_cnt < 124) begin
      apply_stimulus(1);
      edge_cnt++;
    end
    clk1_cnt  = 0;
    last_rise = 0;
    prev_sync = sync_a;
    for (int b = 0; b < 8; b++) begin
      p1_cnt[b] = 0;
      p2_cnt[b] = 0;
    end
    while (edge_cnt < 320) begin
      apply_stimulus(1);
      edge_cnt++;
      p1_hist.push_back(p1_a);
      if (p1_hist.size() == 5) begin
        old_p1 = p1_hist.pop_front();
        if (edge_cnt >= 129) begin
          check_output("p2 lags p1 by 4", 32'(p2_a), 32'(old_p1));
        end
      end
      if (edge_cnt >= 129) begin
        check_output("comp formula", 32'(comp_a),
                     32'(p2_a[3] | p2_a[4] | (clk1_a & ~(p1_a[3] | p2_a[3]))));
        check_output("p1 onehot", 32'($countones(p1_a)), 32'd1);
        check_output("p2 onehot", 32'($countones(p2_a)), 32'd1);
        if (clk1_a) clk1_cnt++;
        for (int b = 0; b < 8; b++) begin
          if (p1_a[b]) p1_cnt[b]++;
          if (p2_a[b]) p2_cnt[b]++;
        end
        if (sync_a && !prev_sync) begin
          if (last_rise != 0) begin
            check_output("sync period", 32'(edge_cnt - last_rise), 32'd64);
          end
          last_rise = edge_cnt;
        end
      end
      prev_sync = sync_a;
    end
    check_output("clk1 high count", 32'(clk1_cnt), 32'd48);
    for (int b = 0; b < 8; b++) begin
      check_output($sformatf("p1[%0d] high count", b), 32'(p1_cnt[b]), 32'd24);
      check_output($sformatf("p2[%0d] high count", b), 32'(p2_cnt[b]), 32'd24);
    end

    $display("[TB] reset pulse during M2 Q1 (dut_b)");
    rst_b = 1'b1;
    apply_stimulus(35);
    check_output("b pre sub", 32'(sub_b), 32'd4);
    check_output("b pre p1", 32'(p1_b), 32'h10);
    check_output("b pre p2", 32'(p2_b), 32'h08);
    check_output("b pre poc", 32'(poc_b), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check_output("b async strobes", 32'({p1_b, p2_b}), 32'd0);
    check_output("b async clocks", 32'({clk1_b, clk2_b, sync_b, comp_b}), 32'd0);
    check_output("b async poc", 32'(poc_b), 32'd1);
    check_output("b async sub", 32'(sub_b), 32'd7);
    @(negedge sysclk);
    apply_stimulus(2);
    rst_b = 1'b1;
    apply_stimulus(1);
    check_output("b restart sync", 32'(sync_b), 32'd1);
    check_output("b restart p1", 32'(p1_b), 32'h01);
    check_output("b restart p2", 32'(p2_b), 32'h00);
    check_output("b restart sub", 32'(sub_b), 32'd0);
    apply_stimulus(255);
    check_output("b poc at edge 256", 32'(poc_b), 32'd1);
    apply_stimulus(1);
    check_output("b poc at edge 257", 32'(poc_b), 32'd0);
    check_output("b sync at edge 257", 32'(sync_b), 32'd1);

    $display("[TB] PHASE_LEN=1 (dut_c)");
    rst_c = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      apply_stimulus(1);
      check_output($sformatf("c clk1 edge%0d", n), 32'(clk1_c), 32'((n - 1) % 4 == 0));
      check_output($sformatf("c clk2 edge%0d", n), 32'(clk2_c), 32'((n - 1) % 4 == 2));
      check_output($sformatf("c sub edge%0d", n), 32'(sub_c), 32'(((n - 1) / 4) % 8));
      if (n == 32) check_output("c poc edge32", 32'(poc_c), 32'd1);
      if (n == 33) check_output("c poc edge33", 32'(poc_c), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
